// File: rtl/fmdll_lock_det_pkg.sv
// ---------------------------------------------------------------------------
// fmdll_lock_det_pkg
// Shared definitions for the FMDLL lock detector:
//   - default values for the detector parameters (tolerance, lock/unlock
//     strobe counts, acquisition timeout)
//   - width of the delay-line control code
//   - legacy-compatible state encoding (IDLE=0, ACQUIRE=1, LOCKED=2, FAIL=3)
//   - packed struct holding the registered multiplication configuration
// ---------------------------------------------------------------------------
package fmdll_lock_det_pkg;

    localparam int TOL_DEF         = 2;
    localparam int LOCK_CNT_DEF    = 16;
    localparam int UNLOCK_MISS_DEF = 2;
    localparam int TIMEOUT_DEF     = 4096;

    localparam int Q_W = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_FAIL    = 2'd3;

    typedef struct packed {
        logic [1:0] m;
        logic [3:0] n;
    } mult_cfg_t;

endpackage

// File: rtl/fmdll_tol_cmp.sv
// ---------------------------------------------------------------------------
// fmdll_tol_cmp
// Purely combinational tolerance comparator. Forms the absolute difference
// between two control codes using an 11-bit unsigned subtraction and flags
// whether it is within TOL.
// Ports:
//   q_a, q_b : control codes to compare (Q_W bits each)
//   in_tol   : high when |q_a - q_b| <= TOL
// ---------------------------------------------------------------------------
module fmdll_tol_cmp
    import fmdll_lock_det_pkg::*;
#(
    parameter int TOL = TOL_DEF
) (
    input  logic [Q_W-1:0] q_a,
    input  logic [Q_W-1:0] q_b,
    output logic           in_tol
);

    logic [Q_W:0] raw_diff;
    logic [Q_W:0] abs_diff;

    // The subtraction is done one bit wider than the codes so the top bit
    // acts as the borrow; a set borrow means q_b > q_a and the result is
    // two's-complement negated to get the magnitude.
    always_comb begin
        raw_diff = {1'b0, q_a} - {1'b0, q_b};
        abs_diff = raw_diff[Q_W] ? (~raw_diff + (Q_W+1)'(1)) : raw_diff;
        in_tol   = (abs_diff <= (Q_W+1)'(TOL));
    end

endmodule

// File: rtl/fmdll_lock_det.sv
// ---------------------------------------------------------------------------
// fmdll_lock_det
// Lock detector for the FMDLL. Watches the delay-line control code strobed
// from the phase/time controller and declares lock once the code has stayed
// within TOL of a reference for LOCK_CNT consecutive strobes. Lock is dropped
// after UNLOCK_MISS consecutive out-of-tolerance strobes. Acquisition that
// takes TIMEOUT cycles ends in FAIL, which is only left on a change of the
// multiplication configuration (M/N) or a reset.
// Ports:
//   CLK_exit    : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   Q_in        : delay-line control code, valid when q_valid is high
//   q_valid     : one-cycle strobe qualifying Q_in
//   M, N        : multiplication configuration, watched for changes
//   lock        : high while LOCKED
//   lock_lost   : one-cycle pulse on any exit from LOCKED (not on reset)
//   timeout_err : high while FAIL
//   q_lock      : current reference code
//   state       : IDLE=0, ACQUIRE=1, LOCKED=2, FAIL=3
// ---------------------------------------------------------------------------
module fmdll_lock_det
    import fmdll_lock_det_pkg::*;
#(
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int UNLOCK_MISS = UNLOCK_MISS_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic           CLK_exit,
    input  logic           rst_n,
    input  logic [Q_W-1:0] Q_in,
    input  logic           q_valid,
    input  logic [1:0]     M,
    input  logic [3:0]     N,
    output logic           lock,
    output logic           lock_lost,
    output logic           timeout_err,
    output logic [Q_W-1:0] q_lock,
    output logic [1:0]     state
);

    localparam int STABLE_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W   = $clog2(UNLOCK_MISS + 1);
    localparam int TIMER_W  = $clog2(TIMEOUT + 1);

    logic [Q_W-1:0]      q_ref,       q_ref_nxt;
    logic                q_ref_valid, q_ref_valid_nxt;
    logic [STABLE_W-1:0] stable_cnt,  stable_nxt;
    logic [MISS_W-1:0]   miss_cnt,    miss_nxt;
    logic [TIMER_W-1:0]  timer,       timer_nxt;
    mult_cfg_t           cfg_reg,     cfg_nxt;
    logic [1:0]          state_nxt;
    logic                lock_lost_nxt;

    mult_cfg_t cfg_in;
    logic      cfg_changed;
    logic      in_tol;

    assign cfg_in      = '{m: M, n: N};
    assign cfg_changed = (cfg_in != cfg_reg);
    assign q_lock      = q_ref;

    fmdll_tol_cmp #(
        .TOL    (TOL)
    ) u_tol_cmp (
        .q_a    (Q_in),
        .q_b    (q_ref),
        .in_tol (in_tol)
    );

    // Next-state logic. Priority order: IDLE always moves on and captures
    // the config; in every other state a config change beats any strobe,
    // lock or timeout. Inside ACQUIRE a lock reached on the same cycle the
    // timer expires takes precedence over FAIL. All counters saturate at
    // their all-ones value so they can never wrap back into range.
    always_comb begin
        state_nxt       = state;
        q_ref_nxt       = q_ref;
        q_ref_valid_nxt = q_ref_valid;
        stable_nxt      = stable_cnt;
        miss_nxt        = miss_cnt;
        timer_nxt       = timer;
        cfg_nxt         = cfg_reg;
        lock_lost_nxt   = 1'b0;

        if (state == ST_IDLE) begin
            state_nxt       = ST_ACQUIRE;
            cfg_nxt         = cfg_in;
            q_ref_valid_nxt = 1'b0;
            stable_nxt      = '0;
            miss_nxt        = '0;
            timer_nxt       = '0;
        end else if (cfg_changed) begin
            state_nxt       = ST_ACQUIRE;
            cfg_nxt         = cfg_in;
            q_ref_valid_nxt = 1'b0;
            stable_nxt      = '0;
            miss_nxt        = '0;
            timer_nxt       = '0;
            lock_lost_nxt   = (state == ST_LOCKED);
        end else begin
            case (state)
                ST_ACQUIRE: begin
                    if (timer != '1) begin
                        timer_nxt = timer + 1'b1;
                    end
                    if (q_valid && !q_ref_valid) begin
                        q_ref_nxt       = Q_in;
                        q_ref_valid_nxt = 1'b1;
                        stable_nxt      = '0;
                    end else if (q_valid && in_tol) begin
                        if (stable_cnt != '1) begin
                            stable_nxt = stable_cnt + 1'b1;
                        end
                        if (stable_nxt == STABLE_W'(LOCK_CNT)) begin
                            state_nxt = ST_LOCKED;
                            miss_nxt  = '0;
                        end
                    end else if (q_valid) begin
                        q_ref_nxt  = Q_in;
                        stable_nxt = '0;
                    end
                    if (state_nxt != ST_LOCKED && timer_nxt == TIMER_W'(TIMEOUT)) begin
                        state_nxt = ST_FAIL;
                    end
                end
                ST_LOCKED: begin
                    if (q_valid && in_tol) begin
                        miss_nxt = '0;
                    end else if (q_valid) begin
                        if (miss_cnt != '1) begin
                            miss_nxt = miss_cnt + 1'b1;
                        end
                        if (miss_nxt == MISS_W'(UNLOCK_MISS)) begin
                            state_nxt       = ST_ACQUIRE;
                            q_ref_nxt       = Q_in;
                            q_ref_valid_nxt = 1'b1;
                            stable_nxt      = '0;
                            miss_nxt        = '0;
                            timer_nxt       = '0;
                            lock_lost_nxt   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers. The status outputs are decoded from the
    // next state so they line up with the state register; reset clears
    // everything, including lock_lost, so a reset never looks like a loss
    // of lock to downstream logic.
    always_ff @(posedge CLK_exit) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            q_ref       <= '0;
            q_ref_valid <= 1'b0;
            stable_cnt  <= '0;
            miss_cnt    <= '0;
            timer       <= '0;
            cfg_reg     <= '0;
            lock        <= 1'b0;
            lock_lost   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            q_ref       <= q_ref_nxt;
            q_ref_valid <= q_ref_valid_nxt;
            stable_cnt  <= stable_nxt;
            miss_cnt    <= miss_nxt;
            timer       <= timer_nxt;
            cfg_reg     <= cfg_nxt;
            lock        <= (state_nxt == ST_LOCKED);
            lock_lost   <= lock_lost_nxt;
            timeout_err <= (state_nxt == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_fmdll_lock_det.sv
// ---------------------------------------------------------------------------
// tb_fmdll_lock_det
// Self-checking bench for fmdll_lock_det: directed scenarios for lock,
// unlock, miss recovery, timeout, config change and reset, followed by a
// randomized run compared cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_fmdll_lock_det;

    localparam int TOL         = 2;
    localparam int LOCK_CNT    = 16;
    localparam int UNLOCK_MISS = 2;
    localparam int TIMEOUT     = 4096;

    localparam int S_IDLE = 0, S_ACQ = 1, S_LOCKED = 2, S_FAIL = 3;

    logic       clk_exit;
    logic       rst_n;
    logic [9:0] q_in;
    logic       q_valid;
    logic [1:0] m_cfg;
    logic [3:0] n_cfg;
    logic       lock;
    logic       lock_lost;
    logic       timeout_err;
    logic [9:0] q_lock;
    logic [1:0] state;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state, kept as plain integers
    int md_state, md_ref, md_ref_valid, md_stable, md_miss, md_timer;
    int md_m, md_n, md_lock_lost;

    fmdll_lock_det #(
        .TOL         (TOL),
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_MISS (UNLOCK_MISS),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK_exit    (clk_exit),
        .rst_n       (rst_n),
        .Q_in        (q_in),
        .q_valid     (q_valid),
        .M           (m_cfg),
        .N           (n_cfg),
        .lock        (lock),
        .lock_lost   (lock_lost),
        .timeout_err (timeout_err),
        .q_lock      (q_lock),
        .state       (state)
    );

    initial clk_exit = 1'b0;
    always #5 clk_exit = ~clk_exit;

    // Hard stop in case something upstream hangs
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Behavioural model: one call per rising edge with the inputs seen there
    task automatic model_clock();
        bit just_locked;
        md_lock_lost = 0;
        just_locked  = 0;
        if (!rst_n) begin
            md_state = S_IDLE; md_ref = 0; md_ref_valid = 0; md_stable = 0;
            md_miss = 0; md_timer = 0; md_m = 0; md_n = 0;
        end else if (md_state == S_IDLE) begin
            md_state = S_ACQ; md_m = int'(m_cfg); md_n = int'(n_cfg);
            md_ref_valid = 0; md_stable = 0; md_miss = 0; md_timer = 0;
        end else if (int'(m_cfg) != md_m || int'(n_cfg) != md_n) begin
            md_lock_lost = (md_state == S_LOCKED);
            md_state = S_ACQ; md_m = int'(m_cfg); md_n = int'(n_cfg);
            md_ref_valid = 0; md_stable = 0; md_miss = 0; md_timer = 0;
        end else if (md_state == S_ACQ) begin
            md_timer++;
            if (q_valid) begin
                if (!md_ref_valid) begin
                    md_ref = int'(q_in); md_ref_valid = 1; md_stable = 0;
                end else if (absdiff(int'(q_in), md_ref) <= TOL) begin
                    md_stable++;
                    if (md_stable >= LOCK_CNT) begin
                        md_state = S_LOCKED; md_miss = 0; just_locked = 1;
                    end
                end else begin
                    md_ref = int'(q_in); md_stable = 0;
                end
            end
            if (!just_locked && md_timer >= TIMEOUT) md_state = S_FAIL;
        end else if (md_state == S_LOCKED && q_valid) begin
            if (absdiff(int'(q_in), md_ref) <= TOL) begin
                md_miss = 0;
            end else begin
                md_miss++;
                if (md_miss >= UNLOCK_MISS) begin
                    md_state = S_ACQ; md_ref = int'(q_in); md_ref_valid = 1;
                    md_stable = 0; md_miss = 0; md_timer = 0; md_lock_lost = 1;
                end
            end
        end
    endtask

    // Advance one cycle: model sees the same inputs as the DUT at the edge,
    // outputs are then sampled 1ns later
    task automatic tick();
        @(posedge clk_exit);
        model_clock();
        #1;
    endtask

    task automatic strobe(input int code);
        q_valid = 1'b1;
        q_in    = 10'(code);
        tick();
        q_valid = 1'b0;
    endtask

    task automatic strobe_n(input int code, input int count);
        for (int i = 0; i < count; i++) strobe(code);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; q_valid = 1'b0; q_in = 10'd0; m_cfg = 2'd1; n_cfg = 4'd4;
        tick();
        tick();
        check_cnt++;
        if (state !== 2'd0) $display("[TB] FAIL reset_state: got %0d want 0", state);
        else pass_cnt++;
        check_cnt++;
        if ({lock, lock_lost, timeout_err} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b want 000", {lock, lock_lost, timeout_err});
        else pass_cnt++;
        check_cnt++;
        if (q_lock !== 10'd0) $display("[TB] FAIL reset_q_lock: got %0d want 0", q_lock);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if (state !== 2'd1) $display("[TB] FAIL idle_to_acquire: got %0d want 1", state);
        else pass_cnt++;
    endtask

    task automatic test_lock_acquire();
        strobe_n(100, 16);
        check_cnt++;
        if (lock !== 1'b0) $display("[TB] FAIL lock_after_16: got %0b want 0", lock);
        else pass_cnt++;
        strobe(100);
        check_cnt++;
        if (lock !== 1'b1 || state !== 2'd2)
            $display("[TB] FAIL lock_after_17: got lock=%0b state=%0d want lock=1 state=2", lock, state);
        else pass_cnt++;
        check_cnt++;
        if (q_lock !== 10'd100) $display("[TB] FAIL lock_q_lock: got %0d want 100", q_lock);
        else pass_cnt++;
    endtask

    task automatic test_unlock_miss();
        strobe(103);
        check_cnt++;
        if (lock !== 1'b1 || lock_lost !== 1'b0)
            $display("[TB] FAIL unlock_first_miss: got lock=%0b lost=%0b want 1/0", lock, lock_lost);
        else pass_cnt++;
        strobe(104);
        check_cnt++;
        if (lock_lost !== 1'b1 || lock !== 1'b0 || state !== 2'd1)
            $display("[TB] FAIL unlock_second_miss: got lost=%0b lock=%0b state=%0d want 1/0/1",
                     lock_lost, lock, state);
        else pass_cnt++;
        check_cnt++;
        if (q_lock !== 10'd104) $display("[TB] FAIL unlock_q_lock: got %0d want 104", q_lock);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (lock_lost !== 1'b0) $display("[TB] FAIL lock_lost_one_cycle: got %0b want 0", lock_lost);
        else pass_cnt++;
    endtask

    task automatic test_miss_recover();
        strobe_n(100, 17);
        check_cnt++;
        if (lock !== 1'b1) $display("[TB] FAIL relock_100: got %0b want 1", lock);
        else pass_cnt++;
        strobe(103);
        strobe(101);
        check_cnt++;
        if (lock !== 1'b1 || lock_lost !== 1'b0)
            $display("[TB] FAIL recover_stay_locked: got lock=%0b lost=%0b want 1/0", lock, lock_lost);
        else pass_cnt++;
        // miss counter must be back at zero: a single further miss keeps lock
        strobe(103);
        check_cnt++;
        if (lock !== 1'b1) $display("[TB] FAIL recover_miss_cleared: got %0b want 1", lock);
        else pass_cnt++;
        strobe(103);
        check_cnt++;
        if (lock_lost !== 1'b1 || q_lock !== 10'd103)
            $display("[TB] FAIL recover_then_unlock: got lost=%0b q_lock=%0d want 1/103", lock_lost, q_lock);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cycles;
        rst_n = 1'b0; m_cfg = 2'd1; n_cfg = 4'd4;
        tick();
        rst_n = 1'b1;
        tick();
        cycles = 0;
        while (cycles < TIMEOUT + 200) begin
            strobe((cycles % 2 == 0) ? 100 : 110);
            cycles++;
            if (state == 2'd3) break;
        end
        check_cnt++;
        if (cycles !== TIMEOUT || state !== 2'd3)
            $display("[TB] FAIL timeout_cycles: got %0d cycles state=%0d want %0d cycles state=3",
                     cycles, state, TIMEOUT);
        else pass_cnt++;
        check_cnt++;
        if (timeout_err !== 1'b1 || lock !== 1'b0)
            $display("[TB] FAIL timeout_err_set: got err=%0b lock=%0b want 1/0", timeout_err, lock);
        else pass_cnt++;
        strobe_n(300, 20);
        check_cnt++;
        if (state !== 2'd3 || timeout_err !== 1'b1)
            $display("[TB] FAIL fail_held: got state=%0d err=%0b want 3/1", state, timeout_err);
        else pass_cnt++;
        n_cfg = 4'd5;
        tick();
        check_cnt++;
        if (state !== 2'd1 || timeout_err !== 1'b0 || lock_lost !== 1'b0)
            $display("[TB] FAIL fail_exit_cfg: got state=%0d err=%0b lost=%0b want 1/0/0",
                     state, timeout_err, lock_lost);
        else pass_cnt++;
    endtask

    task automatic test_cfg_change_strobe();
        strobe_n(200, 17);
        check_cnt++;
        if (lock !== 1'b1) $display("[TB] FAIL cfg_prelock: got %0b want 1", lock);
        else pass_cnt++;
        m_cfg = 2'd2;
        strobe(200);
        check_cnt++;
        if (lock_lost !== 1'b1 || lock !== 1'b0 || state !== 2'd1)
            $display("[TB] FAIL cfg_change_exit: got lost=%0b lock=%0b state=%0d want 1/0/1",
                     lock_lost, lock, state);
        else pass_cnt++;
        // With the coinciding strobe ignored and counters cleared, the next
        // strobe reloads the reference, so lock needs 17 more strobes
        strobe_n(200, 16);
        check_cnt++;
        if (lock !== 1'b0) $display("[TB] FAIL cfg_strobe_ignored: got lock=%0b want 0", lock);
        else pass_cnt++;
        strobe(200);
        check_cnt++;
        if (lock !== 1'b1) $display("[TB] FAIL cfg_relock: got lock=%0b want 1", lock);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_lock();
        rst_n = 1'b0;
        tick();
        check_cnt++;
        if ({lock, lock_lost, timeout_err} !== 3'b000 || state !== 2'd0 || q_lock !== 10'd0)
            $display("[TB] FAIL reset_mid_lock: got lock=%0b lost=%0b err=%0b state=%0d q=%0d want all 0",
                     lock, lock_lost, timeout_err, state, q_lock);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        check_cnt++;
        if (lock_lost !== 1'b0 || state !== 2'd1)
            $display("[TB] FAIL reset_release: got lost=%0b state=%0d want 0/1", lock_lost, state);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int base;
        base = 500;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n   = ($urandom_range(0, 499) != 0);
            q_valid = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) == 0) base = $urandom_range(10, 1000);
            if ($urandom_range(0, 15) == 0) q_in = 10'(base + 5);
            else q_in = 10'(base + $urandom_range(0, 2));
            if ($urandom_range(0, 199) == 0) m_cfg = 2'($urandom);
            if ($urandom_range(0, 199) == 0) n_cfg = 4'($urandom);
            tick();
            check_cnt++;
            if (state !== 2'(md_state))
                $display("[TB] FAIL rand_state cyc %0d: got %0d want %0d", cyc, state, md_state);
            else pass_cnt++;
            check_cnt++;
            if (lock !== (md_state == S_LOCKED) || timeout_err !== (md_state == S_FAIL))
                $display("[TB] FAIL rand_flags cyc %0d: got lock=%0b err=%0b want state %0d",
                         cyc, lock, timeout_err, md_state);
            else pass_cnt++;
            check_cnt++;
            if (lock_lost !== 1'(md_lock_lost))
                $display("[TB] FAIL rand_lock_lost cyc %0d: got %0b want %0d", cyc, lock_lost, md_lock_lost);
            else pass_cnt++;
            check_cnt++;
            if (q_lock !== 10'(md_ref))
                $display("[TB] FAIL rand_q_lock cyc %0d: got %0d want %0d", cyc, q_lock, md_ref);
            else pass_cnt++;
        end
        q_valid = 1'b0;
        rst_n   = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_unlock_miss();
        test_miss_recover();
        test_timeout();
        test_cfg_change_strobe();
        test_reset_mid_lock();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/fmdll_lock_det.md
FMDLL_LOCK_DET -- requirements
Module: fmdll_lock_det

Interface
REQ-001 Parameter TOL, 2: max |Q_in - q_ref| counted as in-tolerance.
REQ-002 Parameter LOCK_CNT, 16: consecutive in-tolerance strobes required for lock.
REQ-003 Parameter UNLOCK_MISS, 2: consecutive out-of-tolerance strobes that drop lock.
REQ-004 Parameter TIMEOUT, 4096: CLK_exit cycles allowed in ACQUIRE before failure.
REQ-005 CLK_exit  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 Q_in  input  10  delay-line control code from the phase/time controller.
REQ-008 q_valid  input  1  one-cycle strobe; Q_in is valid when high.
REQ-009 M  input  2  multiplication config, compared against a registered copy.
REQ-010 N  input  4  multiplication config, compared against a registered copy.
REQ-011 lock  output  1  high while in LOCKED.
REQ-012 lock_lost  output  1  one-cycle pulse on any exit from LOCKED.
REQ-013 timeout_err  output  1  high while in FAIL.
REQ-014 q_lock  output  10  reference code held for the current lock or acquisition.
REQ-015 state  output  2  IDLE=0, ACQUIRE=1, LOCKED=2, FAIL=3.

Function
REQ-016 The FSM SHALL implement states IDLE, ACQUIRE, LOCKED, and FAIL; all outputs are registered.
REQ-017 IDLE SHALL move to ACQUIRE on the next cycle and register M and N.
REQ-018 In ACQUIRE, the first q_valid SHALL load q_ref=Q_in and clear stable_cnt.
- On each later q_valid, when |Q_in-q_ref|<=TOL (unsigned 11-bit difference), stable_cnt SHALL increment.
- Otherwise q_ref SHALL reload with Q_in and stable_cnt SHALL clear to 0.
REQ-019 When the in-tolerance strobe brings stable_cnt to LOCK_CNT, the FSM SHALL enter LOCKED; lock rises the following cycle.
REQ-020 The ACQUIRE timer SHALL clear on entering ACQUIRE, increment every cycle, and enter FAIL when it reaches TIMEOUT with no lock.
REQ-021 If lock and timeout occur on the same cycle, lock SHALL win.
REQ-022 In LOCKED, q_ref SHALL stay frozen.
- An out-of-tolerance strobe SHALL increment miss_cnt; an in-tolerance strobe SHALL clear it.
- When miss_cnt reaches UNLOCK_MISS, the FSM SHALL go to ACQUIRE with q_ref=Q_in and stable_cnt=0, and pulse lock_lost.
REQ-023 FAIL SHALL be held until a config change or reset.
REQ-024 On a config change (M or N differs from the registered copy), from any non-IDLE state, the FSM SHALL do all of the following:
- go to ACQUIRE
- re-register M and N
- clear all counters and mark q_ref invalid
- pulse lock_lost if leaving LOCKED
REQ-025 When a config change and q_valid coincide, the config change SHALL win and the strobe SHALL be ignored.
REQ-026 q_lock SHALL mirror q_ref.
REQ-027 All counters SHALL saturate, never wrap.
REQ-028 Q_in SHALL be ignored when q_valid is low.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL reset to:
- state=IDLE
- lock=0, lock_lost=0, timeout_err=0, q_lock=0
- all counters 0, registered M/N = 0
REQ-030 Reset asserted mid-lock SHALL drop lock on the next edge without pulsing lock_lost.

Structure
REQ-031 The state encoding and the default parameter constants SHALL live in the shared FMDLL package.
REQ-032 One sub-module, fmdll_tol_cmp, SHALL compute the absolute difference and the in-tolerance flag combinationally.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- 17 strobes with Q_in=100 -> lock=1 one cycle after the 17th strobe; q_lock=100.
- Locked at 100, strobes 103 then 104 -> lock_lost pulses after the second strobe; state=ACQUIRE; q_lock=104.
- Locked, strobes 103 then 101 -> lock stays 1; miss_cnt returns to 0.
- Q_in alternating 100/110 for 4096 cycles -> state=FAIL and timeout_err=1; a change of N from 4 to 5 -> state=ACQUIRE and timeout_err=0.
- Locked, M changes in the same cycle as a q_valid -> lock_lost pulse; the strobe is ignored; counters are 0.
- rst_n low for one edge while locked -> all outputs 0 and no lock_lost pulse.
